// File: rtl/distribuidor_papeis.sv
// Role-distribution controller for one game round: seed selection, seed ROM fetch,
// then per-player class reveal driven by edge-detected button presses.
module distribuidor_papeis #(
  parameter int N_JOGADORES = 5,
  parameter int W_CLASSE    = 2,
  parameter int N_SEEDS     = 20,
  parameter int W_SEED      = 5,
  parameter int CLASSE_LOBO = 1
) (
  input  logic                            clock,
  input  logic                            rst_global_n,
  input  logic                            iniciar,
  input  logic                            botao,
  input  logic                            confirma,
  input  logic                            cancela,
  input  logic [N_JOGADORES*W_CLASSE-1:0] seed_data,
  output logic [W_SEED-1:0]               seed_addr,
  output logic [N_JOGADORES*W_CLASSE-1:0] jogo_atual,
  output logic [$clog2(N_JOGADORES)-1:0]  jogador,
  output logic [W_CLASSE-1:0]             classe_atual,
  output logic                            classe_valida,
  output logic                            fim_rodada,
  output logic [$clog2(N_JOGADORES+1)-1:0] n_lobos,
  output logic [2:0]                      db_estado
);

  localparam int W_J    = $clog2(N_JOGADORES);
  localparam int W_L    = $clog2(N_JOGADORES + 1);
  localparam int W_JOGO = N_JOGADORES * W_CLASSE;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    ESCOLHA = 3'd1,
    CARREGA = 3'd2,
    LATCH   = 3'd3,
    REVELA  = 3'd4,
    FIM     = 3'd5
  } estado_t;

  estado_t           estado_reg, estado_next;
  logic [W_SEED-1:0] seed_addr_reg, seed_addr_next;
  logic [W_JOGO-1:0] jogo_reg, jogo_next;
  logic [W_J-1:0]    jogador_reg, jogador_next;
  logic              botao_prev_reg, confirma_prev_reg;
  logic              botao_pulso, confirma_pulso;
  logic [N_JOGADORES-1:0] eh_lobo;
  logic [W_L-1:0]    n_lobos_soma;

  assign botao_pulso    = botao & ~botao_prev_reg;
  assign confirma_pulso = confirma & ~confirma_prev_reg;

  always_ff @(posedge clock or negedge rst_global_n) begin
    if (!rst_global_n) begin
      estado_reg        <= OCIOSO;
      seed_addr_reg     <= '0;
      jogo_reg          <= '0;
      jogador_reg       <= '0;
      botao_prev_reg    <= 1'b0;
      confirma_prev_reg <= 1'b0;
    end else begin
      estado_reg        <= estado_next;
      seed_addr_reg     <= seed_addr_next;
      jogo_reg          <= jogo_next;
      jogador_reg       <= jogador_next;
      botao_prev_reg    <= botao;
      confirma_prev_reg <= confirma;
    end
  end

  // Cancel outranks every other input in all states but idle.
  always_comb begin
    estado_next    = estado_reg;
    seed_addr_next = seed_addr_reg;
    jogo_next      = jogo_reg;
    jogador_next   = jogador_reg;
    if (cancela && estado_reg != OCIOSO) begin
      estado_next  = OCIOSO;
      jogo_next    = '0;
      jogador_next = '0;
    end else begin
      case (estado_reg)
        OCIOSO: begin
          if (iniciar) begin
            estado_next    = ESCOLHA;
            seed_addr_next = '0;
          end
        end
        ESCOLHA: begin
          if (confirma_pulso) begin
            estado_next = CARREGA;
          end else if (botao_pulso) begin
            seed_addr_next = (seed_addr_reg == W_SEED'(N_SEEDS - 1)) ? '0 : seed_addr_reg + 1'b1;
          end
        end
        CARREGA: estado_next = LATCH;
        LATCH: begin
          jogo_next    = seed_data;
          jogador_next = '0;
          estado_next  = REVELA;
        end
        REVELA: begin
          if (botao_pulso) begin
            if (jogador_reg == W_J'(N_JOGADORES - 1)) estado_next = FIM;
            else                                      jogador_next = jogador_reg + 1'b1;
          end
        end
        FIM: begin
          if (iniciar) estado_next = ESCOLHA;
        end
        default: estado_next = OCIOSO;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_JOGADORES; gi++) begin : g_lobo
      assign eh_lobo[gi] = (jogo_reg[gi*W_CLASSE +: W_CLASSE] == W_CLASSE'(CLASSE_LOBO));
    end
  endgenerate

  always_comb begin
    n_lobos_soma = '0;
    for (int i = 0; i < N_JOGADORES; i++) begin
      n_lobos_soma = n_lobos_soma + W_L'(eh_lobo[i]);
    end
  end

  assign seed_addr     = seed_addr_reg;
  assign jogo_atual    = jogo_reg;
  assign jogador       = jogador_reg;
  assign classe_atual  = jogo_reg[jogador_reg*W_CLASSE +: W_CLASSE];
  assign classe_valida = (estado_reg == REVELA);
  assign fim_rodada    = (estado_reg == FIM);
  assign n_lobos       = n_lobos_soma;
  assign db_estado     = estado_reg;

endmodule
